exu_lsu_ctrl: RTL and testbench
===============================

Name: exu_lsu_ctrl

Overview:
Sequencer between the execute stage and the load/store bus. It accepts one load/store request per transaction; the address is the AGU add result from the EXU datapath. It drives the address/write handshake on the exu_addr / lsu_wr bus, waits for read data, and aligns and extends the returned load data. It then presents a single-cycle register-file writeback, and stalls the pipeline while a transaction is outstanding.

Parameters:
ADDR_WIDTH, 32, width of exu_addr / i_req_addr
RFIDX_WIDTH, 5, register-file index width
TIMEOUT, 255, max cycles waiting in any bus state before abort; 0 disables timeout
CNT_WIDTH, 8, timeout counter width (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req_vld  in  1  EXU load/store request valid
o_req_rdy  out  1  controller can accept a request (state IDLE)
i_req_wr  in  1  1=store, 0=load
i_req_addr  in  ADDR_WIDTH  byte address from AGU
i_req_wdata  in  32  store data (rs2)
i_req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
i_req_unsigned  in  1  zero-extend load (LBU/LHU)
i_req_rd_idx  in  RFIDX_WIDTH  load destination register
exu_addr  out  ADDR_WIDTH  bus address, word aligned ({addr[ADDR_WIDTH-1:2],2'b00})
exu_addr_vld  out  1  bus request valid
lsu_wr  out  1  bus request is write
o_data  out  32  store data, lane-replicated
o_wstrb  out  4  byte write strobes
lsu_wready  in  1  bus accepts write
lsu_rready  in  1  bus accepts read address
i_data  in  32  read data word
i_datavld  in  1  read data valid
o_wb_vld  out  1  writeback pulse
o_wb_rd_idx  out  RFIDX_WIDTH  writeback register index
o_wb_data  out  32  aligned, extended load result
o_stall  out  1  pipeline hold (state != IDLE)
o_misalign  out  1  misaligned-access pulse
o_bus_err  out  1  timeout abort pulse

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE; o_req_rdy=1.
  - All other outputs 0: exu_addr, o_data, o_wstrb, o_wb_data, o_wb_rd_idx, exu_addr_vld, lsu_wr, o_wb_vld, o_stall, o_misalign, o_bus_err.
  - Timeout counter 0.
- States: IDLE, WR_REQ, RD_REQ, RD_DATA, WB.
- IDLE, o_req_rdy=1:
  - Request accepted when i_req_vld=1.
  - Misaligned if size=01 with addr[0]=1, or size=1x with addr[1:0]!=0. A misaligned request produces no bus activity; o_misalign=1 for exactly the next cycle; state stays IDLE.
  - An aligned request registers address, size, unsigned, rd_idx, offset=addr[1:0] and goes to WR_REQ (store) or RD_REQ (load).
- Store data and strobes, registered on accept:
  - Byte: o_data={4{wdata[7:0]}}, o_wstrb=4'b0001<<offset.
  - Half: o_data={2{wdata[15:0]}}, o_wstrb=4'b0011<<offset.
  - Word: o_data=wdata, o_wstrb=4'b1111.
- WR_REQ:
  - exu_addr_vld=1, lsu_wr=1; exu_addr, o_data and o_wstrb held stable.
  - Handshake is exu_addr_vld & lsu_wready. It goes to IDLE with exu_addr_vld=0 the following cycle.
  - Minimum store latency: 2 cycles accept-to-IDLE.
- RD_REQ:
  - exu_addr_vld=1, lsu_wr=0, until lsu_rready=1, then go to RD_DATA.
  - If i_datavld=1 in the same cycle as lsu_rready, the data is captured and the next state is WB.
- RD_DATA:
  - exu_addr_vld=0; waits for i_datavld.
  - On i_datavld, select a lane by offset:
    - Byte: i_data[8*offset+:8].
    - Half: i_data[16*offset[1]+:16].
  - Sign-extend unless unsigned; register into o_wb_data; go to WB.
- WB: o_wb_vld=1 for exactly one cycle with o_wb_rd_idx, then IDLE. The pulse is issued even when rd_idx=0; the register file discards it.
- i_datavld outside RD_REQ/RD_DATA and lsu_wready/lsu_rready in IDLE are ignored.
- Timeout:
  - The counter clears on entry to WR_REQ/RD_REQ/RD_DATA and increments each cycle spent in them.
  - If it reaches TIMEOUT before the awaited handshake, then o_bus_err=1 for one cycle, the state goes to IDLE, exu_addr_vld drops the next cycle, and there is no writeback.
  - If the handshake arrives on the same cycle the counter reaches TIMEOUT, the handshake wins.
- o_stall=1 in every non-IDLE state; o_stall=0 in the cycle of accept (the EXU holds the instruction via o_req_rdy).
- Reset asserted mid-transaction aborts immediately to IDLE with all pulses cleared; no writeback.

Test Plan:
1. LW addr=0x100, rready=1 at cycle 1, datavld with i_data=0xDEADBEEF at cycle 3 -> exu_addr=0x100, lsu_wr=0; o_wb_data=0xDEADBEEF, o_wb_vld for one cycle at cycle 4.
2. LB addr=0x203, i_data=0x80FF_0000, signed -> o_wb_data=0xFFFFFF80; same as LBU -> 0x00000080; LH addr=0x202 with the same data, signed -> 0xFFFF80FF.
3. SB addr=0x301, wdata=0x12345678, lsu_wready held 0 for 3 cycles then 1 -> exu_addr=0x300, o_wstrb=0010, o_data=0x78787878 stable throughout, o_stall high 4 cycles, no o_wb_vld.
4. LW addr=0x102 and SH addr=0x101 -> o_misalign pulse, exu_addr_vld never asserted, o_req_rdy stays 1.
5. TIMEOUT=4, load with lsu_rready never asserted -> o_bus_err pulse after 4 cycles in RD_REQ, return to IDLE, no o_wb_vld; next request accepted normally.
6. rst_n pulled low while in RD_DATA -> outputs 0 immediately, o_req_rdy=1; later arrival of i_datavld does not produce o_wb_vld.

Source files
------------

// File: rtl/exu_lsu_ctrl.sv
`timescale 1ns/1ps
// exu_lsu_ctrl: sequences one load/store at a time between the EXU and the
// load/store bus.
//   Request side : i_req_* in, o_req_rdy out (high only in IDLE).
//   Bus side     : exu_addr/exu_addr_vld/lsu_wr/o_data/o_wstrb out;
//                  lsu_wready, lsu_rready, i_data, i_datavld in.
//   Writeback    : o_wb_vld pulse with o_wb_rd_idx / o_wb_data.
//   Status       : o_stall (not IDLE), o_misalign / o_bus_err pulses.
module exu_lsu_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int TIMEOUT     = 255,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_req_vld,
  output logic                   o_req_rdy,
  input  logic                   i_req_wr,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [31:0]            i_req_wdata,
  input  logic [1:0]             i_req_size,
  input  logic                   i_req_unsigned,
  input  logic [RFIDX_WIDTH-1:0] i_req_rd_idx,
  output logic [ADDR_WIDTH-1:0]  exu_addr,
  output logic                   exu_addr_vld,
  output logic                   lsu_wr,
  output logic [31:0]            o_data,
  output logic [3:0]             o_wstrb,
  input  logic                   lsu_wready,
  input  logic                   lsu_rready,
  input  logic [31:0]            i_data,
  input  logic                   i_datavld,
  output logic                   o_wb_vld,
  output logic [RFIDX_WIDTH-1:0] o_wb_rd_idx,
  output logic [31:0]            o_wb_data,
  output logic                   o_stall,
  output logic                   o_misalign,
  output logic                   o_bus_err
);
  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_RD_REQ, S_RD_DATA, S_WB} state_e;

  // Counter value in the last allowed cycle of a bus state.
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_e                 state_q;
  logic [1:0]             size_q, off_q;
  logic                   uns_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   addr_vld_q, wr_q, wb_vld_q, misalign_q, bus_err_q;
  logic [31:0]            data_q, wb_data_q;
  logic [3:0]             wstrb_q;
  logic [RFIDX_WIDTH-1:0] wb_idx_q;

  logic        misalign_d, to_hit_d;
  logic [31:0] wdata_d, ld_data_d;
  logic [3:0]  wstrb_d;
  logic [7:0]  ld_byte_d;
  logic [15:0] ld_half_d;

  assign misalign_d = ((i_req_size == 2'b01) & i_req_addr[0]) |
                      (i_req_size[1] & (|i_req_addr[1:0]));
  assign to_hit_d   = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Store lane replication and strobes, computed from the incoming request.
  always_comb begin
    wdata_d = i_req_wdata;
    wstrb_d = 4'b1111;
    case (i_req_size)
      2'b00: begin
        wdata_d = {4{i_req_wdata[7:0]}};
        wstrb_d = 4'b0001 << i_req_addr[1:0];
      end
      2'b01: begin
        wdata_d = {2{i_req_wdata[15:0]}};
        wstrb_d = 4'b0011 << i_req_addr[1:0];
      end
      default: ;
    endcase
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    ld_byte_d = i_data[{off_q, 3'b000} +: 8];
    ld_half_d = i_data[{off_q[1], 4'b0000} +: 16];
    ld_data_d = i_data;
    case (size_q)
      2'b00:   ld_data_d = {{24{~uns_q & ld_byte_d[7]}}, ld_byte_d};
      2'b01:   ld_data_d = {{16{~uns_q & ld_half_d[15]}}, ld_half_d};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      off_q      <= '0;
      uns_q      <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      wstrb_q    <= '0;
      wb_vld_q   <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      wb_vld_q   <= 1'b0;
      cnt_q      <= cnt_q + CNT_WIDTH'(1);
      case (state_q)
        S_IDLE: begin
          if (i_req_vld) begin
            if (misalign_d) begin
              misalign_q <= 1'b1;
            end else begin
              addr_q     <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
              size_q     <= i_req_size;
              off_q      <= i_req_addr[1:0];
              uns_q      <= i_req_unsigned;
              cnt_q      <= '0;
              addr_vld_q <= 1'b1;
              wr_q       <= i_req_wr;
              if (i_req_wr) begin
                data_q  <= wdata_d;
                wstrb_q <= wstrb_d;
                state_q <= S_WR_REQ;
              end else begin
                wb_idx_q <= i_req_rd_idx;
                state_q  <= S_RD_REQ;
              end
            end
          end
        end
        S_WR_REQ: begin
          if (lsu_wready) begin
            addr_vld_q <= 1'b0;
            wr_q       <= 1'b0;
            state_q    <= S_IDLE;
          end else if (to_hit_d) begin
            addr_vld_q <= 1'b0;
            wr_q       <= 1'b0;
            bus_err_q  <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          if (lsu_rready) begin
            addr_vld_q <= 1'b0;
            cnt_q      <= '0;
            // Data may come back in the same cycle the address is taken.
            if (i_datavld) begin
              wb_data_q <= ld_data_d;
              wb_vld_q  <= 1'b1;
              state_q   <= S_WB;
            end else begin
              state_q   <= S_RD_DATA;
            end
          end else if (to_hit_d) begin
            addr_vld_q <= 1'b0;
            bus_err_q  <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_RD_DATA: begin
          if (i_datavld) begin
            wb_data_q <= ld_data_d;
            wb_vld_q  <= 1'b1;
            state_q   <= S_WB;
          end else if (to_hit_d) begin
            bus_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_WB:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_rdy    = (state_q == S_IDLE);
  assign o_stall      = (state_q != S_IDLE);
  assign exu_addr     = addr_q;
  assign exu_addr_vld = addr_vld_q;
  assign lsu_wr       = wr_q;
  assign o_data       = data_q;
  assign o_wstrb      = wstrb_q;
  assign o_wb_vld     = wb_vld_q;
  assign o_wb_rd_idx  = wb_idx_q;
  assign o_wb_data    = wb_data_q;
  assign o_misalign   = misalign_q;
  assign o_bus_err    = bus_err_q;
endmodule

// File: tb/tb_exu_lsu_ctrl.sv
`timescale 1ns/1ps
module tb_exu_lsu_ctrl;
  localparam int TO = 4;

  localparam int K_MIS = 0, K_ST_OK = 1, K_ST_ERR = 2, K_LD_OK = 3, K_LD_ERR = 4;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [4:0]  rd;
    logic [31:0] wb;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_req_vld = 0, i_req_wr = 0, i_req_unsigned = 0;
  logic [31:0] i_req_addr = 0, i_req_wdata = 0, i_data = 0;
  logic [1:0]  i_req_size = 0;
  logic [4:0]  i_req_rd_idx = 0;
  logic        lsu_wready = 0, lsu_rready = 0, i_datavld = 0;
  logic        o_req_rdy, exu_addr_vld, lsu_wr, o_wb_vld, o_stall, o_misalign, o_bus_err;
  logic [31:0] exu_addr, o_data, o_wb_data;
  logic [3:0]  o_wstrb;
  logic [4:0]  o_wb_rd_idx;

  exp_t expq[$];
  int   n_cmp = 0, n_bad = 0, stall_cnt = 0;

  exu_lsu_ctrl #(.ADDR_WIDTH(32), .RFIDX_WIDTH(5), .TIMEOUT(TO), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy), .i_req_wr(i_req_wr),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .i_req_rd_idx(i_req_rd_idx),
    .exu_addr(exu_addr), .exu_addr_vld(exu_addr_vld), .lsu_wr(lsu_wr),
    .o_data(o_data), .o_wstrb(o_wstrb), .lsu_wready(lsu_wready), .lsu_rready(lsu_rready),
    .i_data(i_data), .i_datavld(i_datavld),
    .o_wb_vld(o_wb_vld), .o_wb_rd_idx(o_wb_rd_idx), .o_wb_data(o_wb_data),
    .o_stall(o_stall), .o_misalign(o_misalign), .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endfunction

  // Monitor: checks bus cycles and completion pulses against the queue front.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_stall) stall_cnt++;
      if (exu_addr_vld || o_wb_vld || o_bus_err || o_misalign) begin
        if (expq.size() == 0) begin
          chk("unexpected_activity", 1, 0);
        end else begin
          e = expq[0];
          if (exu_addr_vld) begin
            chk("bus_kind", (e.kind != K_MIS), 1);
            chk("bus_addr", exu_addr, e.addr);
            chk("bus_wr", lsu_wr, (e.kind == K_ST_OK || e.kind == K_ST_ERR));
            if (lsu_wr) begin
              chk("st_data", o_data, e.data);
              chk("st_strb", o_wstrb, e.strb);
              if (lsu_wready) begin
                chk("st_done_kind", e.kind, K_ST_OK);
                void'(expq.pop_front());
              end
            end
          end
          if (o_wb_vld) begin
            chk("wb_kind", e.kind, K_LD_OK);
            chk("wb_rd", o_wb_rd_idx, e.rd);
            chk("wb_data", o_wb_data, e.wb);
            void'(expq.pop_front());
          end
          if (o_bus_err) begin
            chk("err_kind", (e.kind == K_ST_ERR || e.kind == K_LD_ERR), 1);
            void'(expq.pop_front());
          end
          if (o_misalign) begin
            chk("mis_kind", e.kind, K_MIS);
            void'(expq.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!o_req_rdy && n < 50) begin step(); n++; end
    chk("idle_wait", o_req_rdy, 1);
  endtask

  // dly: cycles of ready low before the address handshake.
  // dd : 0 = data with the address handshake, k>0 = data in k-th RD_DATA cycle.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [4:0] rd,
                       input int dly, input int dd, input logic [31:0] rdata);
    exp_t e;
    int   off, exp_stall, k;
    logic mis;
    logic [31:0] v;
    wait_idle();
    off = int'(addr[1:0]);
    mis = (size == 2'd1 && addr[0]) || (size >= 2'd2 && off != 0);
    e = '{kind: K_MIS, addr: addr & ~32'h3, data: 0, strb: 0, rd: rd, wb: 0};
    exp_stall = 0;
    if (!mis && wr) begin
      if (size == 0)      begin e.data = {4{wdata[7:0]}};  e.strb = 4'(1 << off); end
      else if (size == 1) begin e.data = {2{wdata[15:0]}}; e.strb = 4'(3 << off); end
      else                begin e.data = wdata;            e.strb = 4'hF; end
      if (dly < TO) begin e.kind = K_ST_OK;  exp_stall = dly + 1; end
      else          begin e.kind = K_ST_ERR; exp_stall = TO; end
    end else if (!mis) begin
      v = rdata;
      if (size == 0) begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (size == 1) begin
        v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      e.wb = v;
      if (dly >= TO)                 begin e.kind = K_LD_ERR; exp_stall = TO; end
      else if (dd >= 1 && dd > TO)   begin e.kind = K_LD_ERR; exp_stall = dly + 1 + TO; end
      else                           begin e.kind = K_LD_OK;  exp_stall = dly + 1 + dd + 1; end
    end
    expq.push_back(e);
    i_req_vld = 1; i_req_wr = wr; i_req_addr = addr; i_req_wdata = wdata;
    i_req_size = size; i_req_unsigned = uns; i_req_rd_idx = rd;
    lsu_wready = 1'($urandom); lsu_rready = 1'($urandom); i_datavld = 1'($urandom);
    step();
    stall_cnt = 0;
    i_req_vld = 0; i_req_addr = $urandom; i_req_wdata = $urandom;
    lsu_wready = 0; lsu_rready = 0; i_datavld = 0;
    if (!mis && wr) begin
      k = 0;
      while (1) begin
        lsu_wready = (k == dly); i_datavld = 1'($urandom);
        step();
        if (k == dly || k == TO - 1) break;
        k++;
      end
    end else if (!mis) begin
      k = 0;
      while (1) begin
        lsu_rready = (k == dly);
        i_datavld  = (k == dly && dd == 0);
        i_data     = i_datavld ? rdata : $urandom;
        step();
        if (k == dly || k == TO - 1) break;
        k++;
      end
      lsu_rready = 0; i_datavld = 0;
      if (k == dly && dd > 0) begin
        k = 0;
        while (1) begin
          i_datavld = (k == dd - 1);
          i_data    = i_datavld ? rdata : $urandom;
          step();
          if (k == dd - 1 || k == TO - 1) break;
          k++;
        end
      end
    end
    lsu_wready = 0; lsu_rready = 0;
    for (int g = 0; g < 2; g++) begin
      i_datavld = 1'($urandom); i_data = $urandom;
      step();
    end
    i_datavld = 0;
    chk("stall_cycles", stall_cnt, exp_stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", o_req_rdy, 1);
    chk("rst_vld", exu_addr_vld, 0);
    chk("rst_addr", exu_addr, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_wb", {o_wb_vld, o_misalign, o_bus_err, lsu_wr}, 0);
    chk("rst_wbdata", o_wb_data, 0);
    rst_n = 1;
    step();

    // Basic word load with data two cycles after the address handshake.
    issue(0, 32'h100, 0, 2'd2, 0, 5'd3, 0, 2, 32'hDEAD_BEEF);
    chk("t1_wbdata", o_wb_data, 32'hDEAD_BEEF);
    // Byte/half extraction and extension.
    issue(0, 32'h203, 0, 2'd0, 0, 5'd4, 0, 1, 32'h80FF_0000);
    chk("t2_lb", o_wb_data, 32'hFFFF_FF80);
    issue(0, 32'h203, 0, 2'd0, 1, 5'd5, 1, 0, 32'h80FF_0000);
    chk("t2_lbu", o_wb_data, 32'h0000_0080);
    issue(0, 32'h202, 0, 2'd1, 0, 5'd0, 0, 1, 32'h80FF_0000);
    chk("t2_lh", o_wb_data, 32'hFFFF_80FF);
    // Byte store with a stalled bus.
    issue(1, 32'h301, 32'h1234_5678, 2'd0, 0, 5'd0, 3, 0, 0);
    chk("t3_addr", exu_addr, 32'h300);
    chk("t3_strb", o_wstrb, 4'b0010);
    chk("t3_data", o_data, 32'h7878_7878);
    // Misaligned requests.
    issue(0, 32'h102, 0, 2'd2, 0, 5'd1, 0, 0, 0);
    issue(1, 32'h101, 32'hAAAA_5555, 2'd1, 0, 5'd1, 0, 0, 0);
    // Read address never accepted, then a normal request.
    issue(0, 32'h500, 0, 2'd2, 0, 5'd7, 10, 0, 0);
    issue(0, 32'h504, 0, 2'd2, 0, 5'd8, 0, 0, 32'h1357_9BDF);
    chk("t5_recover", o_wb_data, 32'h1357_9BDF);
    // Timeout in the data phase, and handshake on the last allowed cycle.
    issue(0, 32'h600, 0, 2'd2, 0, 5'd9, 1, 9, 0);
    issue(0, 32'h604, 0, 2'd2, 0, 5'd9, TO - 1, TO, 32'h2468_ACE0);

    // Reset in RD_DATA: immediate clear, late data ignored.
    wait_idle();
    expq.push_back('{kind: K_LD_OK, addr: 32'h400, data: 0, strb: 0, rd: 5'd2, wb: 0});
    i_req_vld = 1; i_req_wr = 0; i_req_addr = 32'h400; i_req_size = 2'd2; i_req_rd_idx = 5'd2;
    step();
    i_req_vld = 0; lsu_rready = 1;
    step();
    lsu_rready = 0;
    #2 rst_n = 0;
    #1;
    chk("t6_rdy", o_req_rdy, 1);
    chk("t6_vld", exu_addr_vld, 0);
    chk("t6_stall", o_stall, 0);
    chk("t6_addr", exu_addr, 0);
    chk("t6_out", {o_wb_vld, o_misalign, o_bus_err, lsu_wr, o_wstrb}, 0);
    chk("t6_data", o_data, 0);
    void'(expq.pop_front());
    step();
    rst_n = 1; i_datavld = 1; i_data = 32'hFFFF_FFFF;
    repeat (3) step();
    i_datavld = 0;
    chk("t6_nowb", o_wb_data, 0);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      d = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 3));
      issue(1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), 5'($urandom),
            d, int'($urandom_range(0, 5)), $urandom);
    end

    step();
    chk("queue_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
